// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for the two-master, one-slave Wishbone arbiter: instruction (i_*),
// data (d_*) and memory-side (m_*) groups plus the debug grant code.
interface wb_bus_arbiter_if #(
   parameter int unsigned ADR_W = 32
) ();

   // Instruction master
   logic             i_cyc;
   logic             i_stb;
   logic             i_we;
   logic [ADR_W-1:0] i_adr;
   logic [31:0]      i_dat_o;
   logic [3:0]       i_sel;
   logic             i_ack;
   logic             i_err;
   logic [31:0]      i_dat_i;

   // Data master
   logic             d_cyc;
   logic             d_stb;
   logic             d_we;
   logic [ADR_W-1:0] d_adr;
   logic [31:0]      d_dat_o;
   logic [3:0]       d_sel;
   logic             d_ack;
   logic             d_err;
   logic [31:0]      d_dat_i;

   // Memory-side slave port
   logic             m_cyc;
   logic             m_stb;
   logic             m_we;
   logic [ADR_W-1:0] m_adr;
   logic [31:0]      m_dat_o;
   logic [3:0]       m_sel;
   logic             m_ack;
   logic             m_err;
   logic [31:0]      m_dat_i;

   // 00 none, 01 instruction, 10 data
   logic [1:0]       grant;

   // Arbiter view
   modport slave (
      input  i_cyc, i_stb, i_we, i_adr, i_dat_o, i_sel,
      output i_ack, i_err, i_dat_i,
      input  d_cyc, d_stb, d_we, d_adr, d_dat_o, d_sel,
      output d_ack, d_err, d_dat_i,
      output m_cyc, m_stb, m_we, m_adr, m_dat_o, m_sel,
      input  m_ack, m_err, m_dat_i,
      output grant
   );

   // Environment view: both masters and the memory slave
   modport master (
      output i_cyc, i_stb, i_we, i_adr, i_dat_o, i_sel,
      input  i_ack, i_err, i_dat_i,
      output d_cyc, d_stb, d_we, d_adr, d_dat_o, d_sel,
      input  d_ack, d_err, d_dat_i,
      input  m_cyc, m_stb, m_we, m_adr, m_dat_o, m_sel,
      output m_ack, m_err, m_dat_i,
      input  grant
   );

endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter merging instruction fetch and load/store buses onto one
// memory port. A grant is held while the owner keeps cyc high; a watchdog ends any
// access the slave leaves unacknowledged for TIMEOUT_CYCLES stalled cycles.
module wb_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADR_W          = 32
) (
   input logic            clk,
   input logic            rst,
   wb_bus_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   // Encoding doubles as the grant code seen on the debug port
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StGntI = 2'b01,
      StGntD = 2'b10
   } state_e;

   localparam logic LastI = 1'b0;
   localparam logic LastD = 1'b1;

   state_e          state_q, state_d;
   logic            last_q, last_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic             owner_stb;
   logic             timeout;
   logic             term_err;
   logic [ADR_W-1:0] adr_mux;

   // State, last-granted master and watchdog count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         last_q  <= LastI;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Arbitration: lock while owner holds cyc, hand over directly, alternate on contest
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         StIdle: begin
            if (bus.i_cyc && bus.d_cyc) begin
               state_d = (last_q == LastD) ? StGntI : StGntD;
            end else if (bus.i_cyc) begin
               state_d = StGntI;
            end else if (bus.d_cyc) begin
               state_d = StGntD;
            end
         end
         StGntI: begin
            if (!bus.i_cyc) begin
               state_d = bus.d_cyc ? StGntD : StIdle;
            end
         end
         StGntD: begin
            if (!bus.d_cyc) begin
               state_d = bus.i_cyc ? StGntI : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         if (state_d == StGntI) begin
            last_d = LastI;
         end else if (state_d == StGntD) begin
            last_d = LastD;
         end
      end
   end

   // Memory-side mux from the registered owner; zeros when idle
   always_comb begin
      bus.m_cyc   = 1'b0;
      bus.m_stb   = 1'b0;
      bus.m_we    = 1'b0;
      adr_mux     = '0;
      bus.m_dat_o = '0;
      bus.m_sel   = '0;
      owner_stb   = 1'b0;
      case (state_q)
         StGntI: begin
            bus.m_cyc   = bus.i_cyc;
            bus.m_stb   = bus.i_stb;
            bus.m_we    = bus.i_we;
            adr_mux     = bus.i_adr;
            bus.m_dat_o = bus.i_dat_o;
            bus.m_sel   = bus.i_sel;
            owner_stb   = bus.i_stb;
         end
         StGntD: begin
            bus.m_cyc   = bus.d_cyc;
            bus.m_stb   = bus.d_stb;
            bus.m_we    = bus.d_we;
            adr_mux     = bus.d_adr;
            bus.m_dat_o = bus.d_dat_o;
            bus.m_sel   = bus.d_sel;
            owner_stb   = bus.d_stb;
         end
         default: ;
      endcase
   end

   assign bus.m_adr = adr_mux;

   // Termination routing; a real ack beats a coincident watchdog expiry
   always_comb begin
      timeout   = (cnt_q == CntMax) && owner_stb;
      term_err  = bus.m_err || (timeout && !bus.m_ack);
      bus.i_ack = (state_q == StGntI) && bus.m_ack;
      bus.i_err = (state_q == StGntI) && term_err;
      bus.d_ack = (state_q == StGntD) && bus.m_ack;
      bus.d_err = (state_q == StGntD) && term_err;
   end

   // Watchdog: count stalled strobe cycles of the current owner
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle || state_d != state_q || bus.m_ack || bus.m_err || timeout) begin
         cnt_d = '0;
      end else if (owner_stb) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign bus.i_dat_i = bus.m_dat_i;
   assign bus.d_dat_i = bus.m_dat_i;
   assign bus.grant   = state_q;

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master, one-slave Wishbone arbiter that sits directly downstream of `core`. It merges the core's instruction-fetch bus and load/store data bus onto a single memory-side Wishbone port. Grants are round-robin, and a grant stays locked for as long as the owning master holds `cyc`. A watchdog terminates any access the slave never acknowledges, so a missing or dead slave cannot hang the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: stalled cycles allowed before an access is terminated with an error. Legal range 1..65535.
- `ADR_W`, default 32: address width.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `i_cyc`, `i_stb`, `i_we`  in  1 each  instruction master cycle, strobe and write enable.
- `i_adr`  in  ADR_W  instruction master address.
- `i_dat_o`  in  32  instruction master write data.
- `i_sel`  in  4  instruction master byte selects.
- `i_ack`, `i_err`  out  1 each  termination signals to the instruction master.
- `d_cyc`, `d_stb`, `d_we`, `d_adr`, `d_dat_o`, `d_sel`, `d_ack`, `d_err`: data master; same widths, directions and meanings as the `i_*` group.
- `m_cyc`, `m_stb`, `m_we`  out  1 each  memory-side cycle, strobe and write enable.
- `m_adr`  out  ADR_W  memory-side address.
- `m_dat_o`  out  32  memory-side write data.
- `m_sel`  out  4  memory-side byte selects.
- `m_ack`, `m_err`  in  1 each  slave termination.
- `m_dat_i`  in  32  read data from the slave.
- `i_dat_i`, `d_dat_i`  out  32 each  wired directly to `m_dat_i`.
- `grant`  out  2  `00` none, `01` instruction, `10` data; for debug and performance counters.

## Operation
- The state machine has three states: IDLE, GNT_I and GNT_D. State is registered; output muxing is combinational from state.
- A second register, `last`, records the last granted master. Its reset value is "instruction", so the first contested grant goes to data.
- IDLE transitions:
  - Only `i_cyc` high: go to GNT_I.
  - Only `d_cyc` high: go to GNT_D.
  - Both high: grant the master not equal to `last`.
  - Neither high: stay in IDLE.
- GNT_x transitions:
  - Stay while `x_cyc`=1, even across multiple `stb` beats (bus lock).
  - When `x_cyc`=0: if the other master's `cyc`=1, go directly to that master's GNT state; otherwise go to IDLE.
  - `last` updates on every entry to a GNT state.
- Signal routing in GNT_x:
  - All `m_*` outputs equal `x_*`.
  - `x_ack`=`m_ack`, `x_err`=`m_err | timeout`.
  - The other master's `ack`/`err` are 0.
- In IDLE: `m_cyc`, `m_stb`, `m_we` = 0, `m_adr`, `m_dat_o`, `m_sel` = 0, and all master `ack`/`err` = 0.
- Watchdog counter, width clog2(TIMEOUT_CYCLES+1):
  - Cleared in IDLE, on any grant change, and on any `m_ack` or `m_err`.
  - Otherwise increments each cycle the owner has `stb`=1.
  - `timeout` = (count == TIMEOUT_CYCLES) & owner `stb`. It is a one-cycle pulse; the counter clears on the next edge.
  - `timeout` is never driven to the slave; the slave simply sees `stb` dropped or held as the master decides.
- A master dropping `cyc` with an access outstanding abandons that access. A late `m_ack` arriving after the grant has changed goes to the new owner; masters must not drop `cyc` mid-access.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `last`=instruction, counter=0, `grant`=`00`.
  - Combinational outputs follow IDLE: all `m_*` = 0, all `*_ack` = 0, all `*_err` = 0.
  - Applies mid-access as well; no pulse is generated on reset exit.
- Grant latency: `x_cyc` rising in cycle N gives `m_cyc`=1 in cycle N+1. No combinational path exists from `x_cyc` to `m_cyc` while in IDLE.
- Handover: owner drops `cyc` in cycle N while the other master requests; the other master owns the bus in N+1, with no idle cycle.
- `ack`/`err` and read data pass through with zero added latency.
- Simultaneous `m_ack` and timeout in the same cycle: the ack wins, `x_err`=0, and the counter clears.
- Back-to-back beats under one `cyc` need no re-arbitration; one beat per cycle is possible if the slave acks every cycle.

## Test plan
- Reset, then `i_cyc`=`i_stb`=1, `i_adr`=0x100 at cycle 2 → `m_cyc`=1 and `m_adr`=0x100 at cycle 3, `grant`=`01`. Slave acks at cycle 3 → `i_ack`=1 and `d_ack`=0.
- Both masters raise `cyc` together after reset → `d` granted first. `d_cyc` drops → `i` granted the next cycle. Repeat the contest → `d` granted again (alternation).
- Data master holds `cyc` over 4 acked beats while `i_cyc`=1 throughout → `grant` stays `10` for all 4 beats; `i` is granted the cycle after `d_cyc` falls.
- `TIMEOUT_CYCLES`=4, data read with no `m_ack` → `d_err`=1 in exactly the 5th stalled cycle for one cycle; `i_err`=0, counter back to 0.
- `m_ack` arriving in the same cycle the count reaches 4 → `d_ack`=1 and `d_err`=0.
- `rst` asserted while GNT_D with `m_stb`=1 → `m_cyc`=0 and `grant`=`00` immediately, before the next clock edge. After release with only `i_cyc`=1 → `i` granted one cycle later.
